// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID pipeline register.
// Owns the PC and keeps at most one request outstanding to instruction memory.
// A word returned while decode is stalled is parked in hold_q.
// A redirect issued while a request is still in flight is parked in pend_q
// until the stale response arrives and can be dropped.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_stall,
  input  logic        exc,
  input  logic        irq,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus_4,
  output logic        ifid_enable,
  output logic        ifid_mux
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] pend_q;
  logic [31:0] hold_q;

  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;
  logic [31:0] pc_plus_4;
  logic        avail;

  // Redirect target selection: exception wins, then interrupt, branch, jump; word aligned
  always_comb begin
    redirect   = exc | irq | br_taken | jmp;
    target_raw = jmp_target;
    if (exc) begin
      target_raw = EXC_VECTOR;
    end else if (irq) begin
      target_raw = IRQ_VECTOR;
    end else if (br_taken) begin
      target_raw = br_target;
    end
    target    = target_raw & 32'hFFFF_FFFC;
    pc_plus_4 = pc_q + 32'd4;
  end

  // Memory request and IF/ID drive; a redirect always flushes, a stall never bubbles
  always_comb begin
    avail          = ((state == S_REQ) && imem_rvalid) || (state == S_HOLD);
    imem_addr      = pc_q;
    ifid_pc        = pc_q;
    ifid_pc_plus_4 = pc_plus_4;
    ifid_instr     = (state == S_HOLD) ? hold_q : imem_rdata;
    if (reset) begin
      imem_req    = 1'b0;
      ifid_enable = 1'b1;
      ifid_mux    = 1'b0;
    end else begin
      imem_req    = (state == S_REQ) || (state == S_DRAIN);
      ifid_enable = ~id_stall;
      if (redirect) begin
        ifid_mux = 1'b0;
      end else if (id_stall) begin
        ifid_mux = 1'b1;
      end else begin
        ifid_mux = avail;
      end
    end
  end

  // Fetch sequencing: advance, park a stalled word, or drain a stale response after redirect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_REQ;
      pc_q   <= RESET_PC;
      pend_q <= 32'd0;
      hold_q <= 32'd0;
    end else begin
      case (state)
        S_REQ: begin
          if (redirect) begin
            if (imem_rvalid) begin
              pc_q <= target;
            end else begin
              pend_q <= target;
              state  <= S_DRAIN;
            end
          end else if (imem_rvalid) begin
            if (id_stall) begin
              hold_q <= imem_rdata;
              state  <= S_HOLD;
            end else begin
              pc_q <= pc_plus_4;
            end
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc_q  <= target;
            state <= S_REQ;
          end else if (!id_stall) begin
            pc_q  <= pc_plus_4;
            state <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid) begin
            pc_q  <= redirect ? target : pend_q;
            state <= S_REQ;
          end else if (redirect) begin
            pend_q <= target;
          end
        end
        default: begin
          state <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios with literal expectations, then
// randomized stalls, redirects and memory latency against a behavioural model.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;

  logic        clk;
  logic        reset;
  logic        id_stall;
  logic        exc;
  logic        irq;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [31:0] jmp_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus_4;
  logic        ifid_enable;
  logic        ifid_mux;

  int n_checks = 0;
  int n_pass   = 0;

  if_fetch_stage #(
    .RESET_PC  (RESET_PC),
    .IRQ_VECTOR(IRQ_VECTOR),
    .EXC_VECTOR(EXC_VECTOR)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .id_stall      (id_stall),
    .exc           (exc),
    .irq           (irq),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .jmp           (jmp),
    .jmp_target    (jmp_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .ifid_pc_plus_4(ifid_pc_plus_4),
    .ifid_enable   (ifid_enable),
    .ifid_mux      (ifid_mux)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Waits for the next rising edge, then drives one cycle of inputs
  task automatic applyStimulus(input logic stall, input logic e, input logic i,
                               input logic b, input logic [31:0] bt,
                               input logic j, input logic [31:0] jt,
                               input logic v, input logic [31:0] d);
    @(posedge clk);
    #1;
    id_stall    = stall;
    exc         = e;
    irq         = i;
    br_taken    = b;
    br_target   = bt;
    jmp         = j;
    jmp_target  = jt;
    imem_rvalid = v;
    imem_rdata  = d;
    #1;
  endtask

  // Behavioural view of the fetch stage: the PC being fetched, whether a word
  // is parked waiting for decode, and whether a stale response must be thrown away
  logic [31:0] m_pc;
  logic        m_parked;
  logic [31:0] m_parked_word;
  logic        m_discard;
  logic [31:0] m_after_discard;

  initial begin
    logic        redir;
    logic [31:0] tgt;
    logic        delivered;
    logic        e_mux;
    forever begin
      @(negedge clk);
      if (reset) begin
        checkOutput("rst.req", 32'(imem_req), 32'd0);
        checkOutput("rst.mux", 32'(ifid_mux), 32'd0);
        checkOutput("rst.enable", 32'(ifid_enable), 32'd1);
        m_pc      = RESET_PC;
        m_parked  = 1'b0;
        m_discard = 1'b0;
      end else begin
        redir = exc | irq | br_taken | jmp;
        if (exc)           tgt = EXC_VECTOR;
        else if (irq)      tgt = IRQ_VECTOR;
        else if (br_taken) tgt = br_target;
        else               tgt = jmp_target;
        tgt       = (tgt / 4) * 4;
        delivered = m_parked || (!m_discard && imem_rvalid);
        e_mux     = redir ? 1'b0 : (id_stall ? 1'b1 : delivered);

        checkOutput("model.req", 32'(imem_req), 32'(!m_parked));
        if (!m_parked) checkOutput("model.addr", imem_addr, m_pc);
        checkOutput("model.pc", ifid_pc, m_pc);
        checkOutput("model.pc4", ifid_pc_plus_4, m_pc + 32'd4);
        checkOutput("model.enable", 32'(ifid_enable), 32'(!id_stall));
        checkOutput("model.mux", 32'(ifid_mux), 32'(e_mux));
        if (e_mux) checkOutput("model.instr", ifid_instr, m_parked ? m_parked_word : imem_rdata);

        if (m_discard) begin
          if (redir) m_after_discard = tgt;
          if (imem_rvalid) begin
            m_pc      = m_after_discard;
            m_discard = 1'b0;
          end
        end else if (m_parked) begin
          if (redir) begin
            m_pc     = tgt;
            m_parked = 1'b0;
          end else if (!id_stall) begin
            m_pc     = m_pc + 32'd4;
            m_parked = 1'b0;
          end
        end else if (imem_rvalid) begin
          if (redir) begin
            m_pc = tgt;
          end else if (id_stall) begin
            m_parked      = 1'b1;
            m_parked_word = imem_rdata;
          end else begin
            m_pc = m_pc + 32'd4;
          end
        end else if (redir) begin
          m_discard       = 1'b1;
          m_after_discard = tgt;
        end
      end
    end
  end

  int mem_wait;

  // Randomized cycle: stalls, redirects, and a memory with 0..2 cycles of latency
  task automatic randomCycle();
    @(posedge clk);
    #1;
    id_stall   = ($urandom_range(0, 99) < 30);
    exc        = ($urandom_range(0, 99) < 3);
    irq        = ($urandom_range(0, 99) < 3);
    br_taken   = ($urandom_range(0, 99) < 8);
    jmp        = ($urandom_range(0, 99) < 8);
    br_target  = $urandom_range(0, 32'h0000_0FFF);
    jmp_target = $urandom_range(0, 32'h0000_0FFF);
    imem_rdata = $urandom;
    if (imem_req && mem_wait == 0) begin
      imem_rvalid = 1'b1;
      mem_wait    = $urandom_range(0, 2);
    end else begin
      imem_rvalid = 1'b0;
      if (imem_req) mem_wait--;
    end
  endtask

  initial begin
    reset       = 1'b1;
    id_stall    = 1'b0;
    exc         = 1'b0;
    irq         = 1'b0;
    br_taken    = 1'b0;
    br_target   = 32'd0;
    jmp         = 1'b0;
    jmp_target  = 32'd0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    mem_wait    = 0;

    // Reset held with a response on the bus
    #3;
    checkOutput("t1.req_in_reset", 32'(imem_req), 32'd0);
    checkOutput("t1.mux_in_reset", 32'(ifid_mux), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset       = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    checkOutput("t1.addr", imem_addr, RESET_PC);
    checkOutput("t1.req", 32'(imem_req), 32'd1);

    // Zero-wait stream
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h2008_0001);
    checkOutput("t2.pc0", ifid_pc, 32'h0);
    checkOutput("t2.mux0", 32'(ifid_mux), 32'd1);
    checkOutput("t2.instr0", ifid_instr, 32'h2008_0001);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h2009_0002);
    checkOutput("t2.pc4", ifid_pc, 32'h4);
    checkOutput("t2.pc4_plus4", ifid_pc_plus_4, 32'h8);

    // Stall while the word at 0x8 returns
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 32'h200A_0003);
    checkOutput("t3.pc8", ifid_pc, 32'h8);
    checkOutput("t3.enable", 32'(ifid_enable), 32'd0);
    checkOutput("t3.mux", 32'(ifid_mux), 32'd1);
    repeat (2) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
      checkOutput("t3.hold_req", 32'(imem_req), 32'd0);
      checkOutput("t3.hold_mux", 32'(ifid_mux), 32'd1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("t3.held_instr", ifid_instr, 32'h200A_0003);
    checkOutput("t3.held_pc", ifid_pc, 32'h8);
    checkOutput("t3.held_mux", 32'(ifid_mux), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("t3.next_addr", imem_addr, 32'hC);

    // Branch while waiting; late response dropped
    applyStimulus(0, 0, 0, 1, 32'h40, 0, 0, 0, 32'h0);
    checkOutput("t4.flush", 32'(ifid_mux), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    checkOutput("t4.drop_mux", 32'(ifid_mux), 32'd0);
    checkOutput("t4.old_addr", imem_addr, 32'hC);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("t4.new_addr", imem_addr, 32'h40);

    // Exception beats branch in the same cycle
    applyStimulus(0, 1, 0, 1, 32'h100, 0, 0, 1, 32'h3333_3333);
    checkOutput("t5.bubble", 32'(ifid_mux), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h1111_1111);
    checkOutput("t5.addr", imem_addr, EXC_VECTOR);
    checkOutput("t5.mux", 32'(ifid_mux), 32'd1);

    // Interrupt beats jump
    applyStimulus(0, 0, 1, 0, 0, 1, 32'h200, 1, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("t5.irq_addr", imem_addr, IRQ_VECTOR);

    // Jump to an unaligned top-of-memory address, then wrap
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 1, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h2222_2222);
    checkOutput("t6.pc", ifid_pc, 32'hFFFF_FFFC);
    checkOutput("t6.pc_plus_4", ifid_pc_plus_4, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("t6.wrap_addr", imem_addr, 32'h0);

    // Random traffic, with a reset in the middle that drops any in-flight response
    mem_wait = 0;
    repeat (2000) randomCycle();
    @(posedge clk);
    #1;
    reset       = 1'b1;
    imem_rvalid = 1'b0;
    mem_wait    = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2000) randomCycle();

    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
